// File: rtl/memlcd_pkg.sv
// Shared types and field geometry for the memory-LCD line serializer.
package memlcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_MODE,
        ST_ADDR,
        ST_DATA,
        ST_LTRAIL,
        ST_FTRAIL,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int MODE_BITS   = 6;
    localparam int ADDR_BITS   = 10;
    localparam int LTRAIL_BITS = 6;
    localparam int FTRAIL_BITS = 16;
    localparam int SCS_SETUP   = 4;
    localparam int SCS_HOLD    = 4;
    localparam int SCS_GAP     = 8;

    // Bit positions inside the mode field, position 0 goes out first
    localparam int MODE_M0 = 0;
    localparam int MODE_M1 = 1;
    localparam int MODE_M2 = 2;

    localparam int DEF_CLK_DIV     = 2;
    localparam int DEF_LINE_PIXELS = 336;
    localparam int DEF_LINES       = 536;

    // Mode field laid out LSB-first so it can be loaded straight into the shifter
    function automatic logic [31:0] mode_word(input logic clear, input logic vcom);
        logic [31:0] m;
        m          = '0;
        m[MODE_M0] = ~clear;
        m[MODE_M1] = vcom;
        m[MODE_M2] = clear;
        return m;
    endfunction

endpackage

// File: rtl/memlcd_bit_timer.sv
// Divides clk into serial bit slots: sclk low for CLK_DIV cycles, then high for CLK_DIV.
module memlcd_bit_timer #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic bit_tick
);

    localparam int CW = $clog2(2 * CLK_DIV);

    logic [CW-1:0] cnt;

    // Phase counter runs only while enabled and wraps at the end of each bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Last cycle of a bit and the high half of the bit are decoded from the count
    always_comb begin
        bit_tick = en && (cnt == CW'(2 * CLK_DIV - 1));
        sclk     = en && (cnt >= CW'(CLK_DIV));
    end

endmodule

// File: rtl/memlcd_line_serializer.sv
// Sends memory-LCD update or all-clear frames, streaming line pixels from the framebuffer.
module memlcd_line_serializer
    import memlcd_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int LINE_PIXELS = DEF_LINE_PIXELS,
    parameter int LINES       = DEF_LINES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic        vcom,
    input  logic [9:0]  line_first,
    input  logic [9:0]  line_last,
    output logic        fb_rd,
    output logic [19:0] fb_addr,
    input  logic [31:0] fb_data,
    output logic        busy,
    output logic        done,
    output logic        lcd_sclk,
    output logic        lcd_si,
    output logic        lcd_scs
);

    localparam int WORDS     = (LINE_PIXELS + 31) / 32;
    localparam int LAST_BITS = LINE_PIXELS - 32 * (WORDS - 1);
    localparam int FW        = $clog2(WORDS + 1);

    state_t        state, state_nxt;
    logic [3:0]    cyc_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   sh, pf;
    logic          pf_full, rd_pend, clear_r;
    logic [9:0]    line_cur, line_end, lf, ll;
    logic [FW-1:0] fetch_idx, word_idx;
    logic          bit_en, bit_tick, field_last, word_last, last_word, pf_take;

    memlcd_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .en       (bit_en),
        .sclk     (lcd_sclk),
        .bit_tick (bit_tick)
    );

    // Clamp the requested line range to something the panel can take
    always_comb begin
        lf = (line_first >= 10'(LINES)) ? 10'(LINES - 1) : line_first;
        ll = ((line_last < lf) || (line_last >= 10'(LINES))) ? lf : line_last;
    end

    // Field-end and word-end decodes shared by the FSM and the datapath
    always_comb begin
        last_word  = (word_idx == FW'(WORDS - 1));
        word_last  = (bit_cnt == 5'd31);
        field_last = 1'b0;
        case (state)
            ST_MODE:   field_last = (bit_cnt == 5'(MODE_BITS - 1));
            ST_ADDR:   field_last = (bit_cnt == 5'(ADDR_BITS - 1));
            ST_DATA:   field_last = last_word && (bit_cnt == 5'(LAST_BITS - 1));
            ST_LTRAIL: field_last = (bit_cnt == 5'(LTRAIL_BITS - 1));
            ST_FTRAIL: field_last = (bit_cnt == 5'(FTRAIL_BITS - 1));
            default:   field_last = 1'b0;
        endcase
        pf_take = bit_tick &&
                  (((state == ST_ADDR) && field_last && !clear_r) ||
                   ((state == ST_DATA) && !field_last && word_last && !last_word));
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fields advance on the final tick of their last bit
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SETUP;
            ST_SETUP:  if (cyc_cnt == 4'(SCS_SETUP - 1)) state_nxt = ST_MODE;
            ST_MODE:   if (bit_tick && field_last) state_nxt = ST_ADDR;
            ST_ADDR:   if (bit_tick && field_last) state_nxt = clear_r ? ST_HOLD : ST_DATA;
            ST_DATA:   if (bit_tick && field_last) state_nxt = ST_LTRAIL;
            ST_LTRAIL: if (bit_tick && field_last)
                           state_nxt = (line_cur == line_end) ? ST_FTRAIL : ST_ADDR;
            ST_FTRAIL: if (bit_tick && field_last) state_nxt = ST_HOLD;
            ST_HOLD:   if (cyc_cnt == 4'(SCS_HOLD - 1)) state_nxt = ST_GAP;
            ST_GAP:    if (cyc_cnt == 4'(SCS_GAP - 1)) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: command latch, bit/word/line counters, shifter and one-word prefetch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            pf        <= '0;
            pf_full   <= 1'b0;
            rd_pend   <= 1'b0;
            clear_r   <= 1'b0;
            line_cur  <= '0;
            line_end  <= '0;
            fetch_idx <= '0;
            word_idx  <= '0;
        end else begin
            cyc_cnt <= (state_nxt != state) ? 4'd0 : cyc_cnt + 4'd1;
            rd_pend <= fb_rd;
            if (rd_pend) begin
                pf      <= fb_data;
                pf_full <= 1'b1;
            end else if (pf_take) begin
                pf_full <= 1'b0;
            end
            if (fb_rd) begin
                fetch_idx <= fetch_idx + FW'(1);
            end
            if ((state == ST_IDLE) && start) begin
                clear_r   <= clear;
                sh        <= mode_word(clear, vcom);
                line_cur  <= lf;
                line_end  <= ll;
                fetch_idx <= '0;
                word_idx  <= '0;
                bit_cnt   <= '0;
                pf_full   <= 1'b0;
            end
            if (bit_tick) begin
                case (state)
                    ST_MODE: begin
                        bit_cnt <= field_last ? 5'd0 : bit_cnt + 5'd1;
                        sh      <= !field_last ? (sh >> 1)
                                 : (clear_r ? 32'd0 : 32'(line_cur) + 32'd1);
                    end
                    ST_ADDR: begin
                        bit_cnt  <= field_last ? 5'd0 : bit_cnt + 5'd1;
                        sh       <= field_last ? pf : (sh >> 1);
                        word_idx <= '0;
                    end
                    ST_DATA: begin
                        if (field_last) begin
                            bit_cnt <= 5'd0;
                        end else if (word_last) begin
                            bit_cnt  <= 5'd0;
                            sh       <= pf;
                            word_idx <= word_idx + FW'(1);
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            sh      <= sh >> 1;
                        end
                    end
                    ST_LTRAIL: begin
                        if (field_last) begin
                            bit_cnt   <= 5'd0;
                            fetch_idx <= '0;
                            if (line_cur != line_end) begin
                                line_cur <= line_cur + 10'd1;
                                sh       <= 32'(line_cur) + 32'd2;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                    ST_FTRAIL: bit_cnt <= field_last ? 5'd0 : bit_cnt + 5'd1;
                    default:   bit_cnt <= bit_cnt;
                endcase
            end
        end
    end

    // Outputs decoded from state; si is the shifter LSB only in fields that carry data
    always_comb begin
        busy    = (state != ST_IDLE);
        lcd_scs = (state == ST_SETUP) || (state == ST_MODE) || (state == ST_ADDR) ||
                  (state == ST_DATA) || (state == ST_LTRAIL) || (state == ST_FTRAIL) ||
                  (state == ST_HOLD);
        bit_en  = (state == ST_MODE) || (state == ST_ADDR) || (state == ST_DATA) ||
                  (state == ST_LTRAIL) || (state == ST_FTRAIL);
        lcd_si  = ((state == ST_MODE) || (state == ST_ADDR) || (state == ST_DATA)) && sh[0];
        done    = (state == ST_GAP) && (cyc_cnt == 4'd0);
        fb_rd   = ((state == ST_ADDR) || (state == ST_DATA)) && !clear_r && !pf_full &&
                  !rd_pend && (fetch_idx < FW'(WORDS));
        fb_addr = 20'(line_cur) * 20'(WORDS) + 20'(fetch_idx);
    end

endmodule
